// File: rtl/mem_data_ctrl.sv
// MEM-stage load/save responder: serialises 1/2/4-byte requests onto a byte-wide synchronous RAM, LSB first.
// Optional macro MEMCTRL_IO_WAIT_EN adds io_buffer_full back-pressure on writes to the IO region.
module mem_data_ctrl #(
  parameter int RAM_ADDR_WIDTH = 17,
  parameter int DATA_WIDTH     = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load,
  input  logic                      save,
  input  logic [31:0]               sl_reg_address,
  input  logic [DATA_WIDTH-1:0]     sl_data,
  input  logic [2:0]                sl_data_length,
  input  logic                      sl_data_signed,
  output logic                      mem_ctrl_done,
  output logic [DATA_WIDTH-1:0]     mem_ctrl_data,
  input  logic [7:0]                mem_din,
  output logic [7:0]                mem_dout,
  output logic [RAM_ADDR_WIDTH-1:0] mem_a,
`ifdef MEMCTRL_IO_WAIT_EN
  input  logic                      io_buffer_full,
`endif
  output logic                      mem_wr
);

  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, WRITE = 2'd2, DONE = 2'd3} state_t;

  state_t                    state_q, state_d;
  logic [2:0]                cnt_q, cnt_d;
  logic [2:0]                nbytes_q, nbytes_d;
  logic                      signed_q, signed_d;
  logic                      io_region_q, io_region_d;
  logic [31:0]               wdata_q, wdata_d;
  logic [23:0]               asm_q, asm_d;
  logic [RAM_ADDR_WIDTH-1:0] mem_a_q, mem_a_d;
  logic [7:0]                mem_dout_q, mem_dout_d;
  logic                      mem_wr_q, mem_wr_d;
  logic                      done_q, done_d;
  logic [DATA_WIDTH-1:0]     data_q, data_d;
  logic                      stall_acc_s, stall_wr_s;
  logic                      unused_s;

  function automatic logic [2:0] len_decode(input logic [2:0] len);
    case (len)
      3'd1:    len_decode = 3'd1;
      3'd2:    len_decode = 3'd2;
      default: len_decode = 3'd4;
    endcase
  endfunction

  // Final byte arrives straight from mem_din, so it is merged here rather than from asm_q.
  function automatic logic [DATA_WIDTH-1:0] extend(input logic [23:0] lo, input logic [7:0] top,
                                                   input logic [2:0] n, input logic sgn);
    case (n)
      3'd1:    extend = {{(DATA_WIDTH-8){sgn & top[7]}}, top};
      3'd2:    extend = {{(DATA_WIDTH-16){sgn & top[7]}}, top, lo[7:0]};
      default: extend = DATA_WIDTH'({top, lo});
    endcase
  endfunction

`ifdef MEMCTRL_IO_WAIT_EN
  assign stall_acc_s = (sl_reg_address[17:16] == 2'b11) && io_buffer_full;
  assign stall_wr_s  = io_region_q && io_buffer_full;
  assign unused_s    = ^sl_reg_address[31:RAM_ADDR_WIDTH];
`else
  assign stall_acc_s = 1'b0;
  assign stall_wr_s  = 1'b0;
  assign unused_s    = ^{sl_reg_address[31:RAM_ADDR_WIDTH], io_region_q};
`endif

  // Next-state and registered-output computation.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    nbytes_d    = nbytes_q;
    signed_d    = signed_q;
    io_region_d = io_region_q;
    wdata_d     = wdata_q;
    asm_d       = asm_q;
    mem_a_d     = mem_a_q;
    mem_dout_d  = mem_dout_q;
    mem_wr_d    = 1'b0;
    done_d      = 1'b0;
    data_d      = data_q;
    case (state_q)
      IDLE: begin
        if (load || save) begin
          nbytes_d    = len_decode(sl_data_length);
          signed_d    = sl_data_signed;
          io_region_d = (sl_reg_address[17:16] == 2'b11);
          wdata_d     = sl_data[31:0];
          mem_a_d     = sl_reg_address[RAM_ADDR_WIDTH-1:0];
          cnt_d       = 3'd0;
          if (load) begin
            state_d = READ;
          end else begin
            state_d    = WRITE;
            mem_dout_d = sl_data[7:0];
            mem_wr_d   = !stall_acc_s;
          end
        end else begin
          state_d = IDLE;
        end
      end
      READ: begin
        // cnt_q counts edges in READ; byte cnt_q-1 is on mem_din this cycle.
        if (cnt_q == nbytes_q) begin
          data_d  = extend(asm_q, mem_din, nbytes_q, signed_q);
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 3'd1;
          case (cnt_q)
            3'd1:    asm_d[7:0]   = mem_din;
            3'd2:    asm_d[15:8]  = mem_din;
            3'd3:    asm_d[23:16] = mem_din;
            default: asm_d        = asm_q;
          endcase
          if (cnt_q < (nbytes_q - 3'd1)) begin
            mem_a_d = mem_a_q + RAM_ADDR_WIDTH'(1);
          end else begin
            mem_a_d = mem_a_q;
          end
        end
      end
      WRITE: begin
        if (!mem_wr_q) begin
          mem_wr_d = !stall_wr_s;
        end else if (cnt_q == (nbytes_q - 3'd1)) begin
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d    = cnt_q + 3'd1;
          mem_a_d  = mem_a_q + RAM_ADDR_WIDTH'(1);
          mem_wr_d = !stall_wr_s;
          case (cnt_q)
            3'd0:    mem_dout_d = wdata_q[15:8];
            3'd1:    mem_dout_d = wdata_q[23:16];
            default: mem_dout_d = wdata_q[31:24];
          endcase
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      nbytes_q    <= 3'd4;
      signed_q    <= 1'b0;
      io_region_q <= 1'b0;
      wdata_q     <= 32'd0;
      asm_q       <= 24'd0;
      mem_a_q     <= {RAM_ADDR_WIDTH{1'b0}};
      mem_dout_q  <= 8'd0;
      mem_wr_q    <= 1'b0;
      done_q      <= 1'b0;
      data_q      <= {DATA_WIDTH{1'b0}};
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      nbytes_q    <= nbytes_d;
      signed_q    <= signed_d;
      io_region_q <= io_region_d;
      wdata_q     <= wdata_d;
      asm_q       <= asm_d;
      mem_a_q     <= mem_a_d;
      mem_dout_q  <= mem_dout_d;
      mem_wr_q    <= mem_wr_d;
      done_q      <= done_d;
      data_q      <= data_d;
    end
  end

  assign mem_ctrl_done = done_q;
  assign mem_ctrl_data = data_q;
  assign mem_dout      = mem_dout_q;
  assign mem_a         = mem_a_q;
  assign mem_wr        = mem_wr_q;

endmodule

// File: doc/mem_data_ctrl.md
Name: mem_data_ctrl

Overview:
- Memory-side responder for the MEM stage load/save request interface.
- Accepts one load or save request at a time (1, 2 or 4 bytes) and serialises it onto the byte-wide synchronous RAM bus, least-significant byte first.
- Returns a one-cycle done pulse; for loads the pulse comes with sign- or zero-extended 32-bit data.
- Sits between the MEM stage (request/done/data) and the external RAM port.

Parameters:
- RAM_ADDR_WIDTH, 17: width of mem_a; the request address is truncated to this width.
- DATA_WIDTH, 32: width of request/return data (`Data_size).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-low reset; 0 = reset.
- load  input  1  load request, level, from MEM stage.
- save  input  1  save request, level, from MEM stage.
- sl_reg_address  input  32  byte address of access.
- sl_data  input  32  store data; low bytes used per length.
- sl_data_length  input  3  byte count: 1, 2 or 4.
- sl_data_signed  input  1  loads: 1 = sign-extend, 0 = zero-extend.
- mem_ctrl_done  output  1  one-cycle completion pulse.
- mem_ctrl_data  output  32  extended load result; held until the next load completes.
- mem_din  input  8  RAM read byte; valid one cycle after its address.
- mem_dout  output  8  RAM write byte.
- mem_a  output  RAM_ADDR_WIDTH  RAM byte address.
- mem_wr  output  1  1 = write mem_dout to mem_a this cycle.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, byte counter=0.
  - mem_a=0, mem_dout=0, mem_wr=0.
  - mem_ctrl_done=0, mem_ctrl_data=0.
  - A transfer in flight is abandoned; no further RAM writes.
- All outputs are registered.
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - Requests are sampled only here.
  - load=1 has priority over save=1 when both are high.
  - On acceptance at edge t0: latch address, length and signed flag (plus sl_data for save); counter=0; mem_a<=address.
  - Load: go to READ, mem_wr<=0.
  - Save: go to WRITE, mem_wr<=1, mem_dout<=sl_data[7:0].
- READ:
  - Each cycle mem_a advances by 1 until byte N-1 has been addressed.
  - The byte for address+i is captured from mem_din one cycle after it was addressed, into assembly bits [8i+7:8i].
  - After byte N-1 is captured, extend from bit 8N-1 (sign or zero) into mem_ctrl_data and go to DONE.
  - mem_ctrl_done is high in cycle t0+N+2.
- WRITE:
  - Byte i is driven on mem_dout at address+i with mem_wr=1 in cycle t0+1+i.
  - After byte N-1: mem_wr<=0, go to DONE.
  - mem_ctrl_done is high in cycle t0+N+1.
- DONE:
  - mem_ctrl_done=1 for exactly one cycle, then IDLE.
  - Minimum one IDLE cycle between requests.
  - A request still asserted in that IDLE cycle is treated as a new request.
- mem_wr is never high outside WRITE.
- mem_a wraps modulo 2^RAM_ADDR_WIDTH.
- Illegal lengths (0, 3, 5, 6, 7) are handled as 4 bytes; the block never hangs.
- Request inputs changing mid-transfer are ignored; latched copies are used.

Optional Feature:
- Macro MEMCTRL_IO_WAIT_EN.
- Defined:
  - Adds input io_buffer_full (1 bit).
  - In WRITE, when latched address[17:16]==2'b11 and io_buffer_full=1: mem_wr=0 and the counter and address hold.
  - The write resumes the cycle after io_buffer_full falls. Done latency grows by the number of stalled cycles.
  - Loads are unaffected.
- Undefined: port absent; WRITE never stalls.

Test Plan:
- Load, word: RAM[0x100..0x103]=78,56,34,12; load=1, length=4, signed=0 at t0 -> mem_ctrl_done=1 only in t0+6, mem_ctrl_data=0x12345678.
- Load, byte, sign vs zero extension: RAM[0x200]=0x80, length=1. signed=1 -> 0xFFFFFF80 at t0+3. signed=0 -> 0x00000080.
- Save, halfword: sl_data=0x0000ABCD, length=2, address 0x300 -> mem_wr=1 with (0x300,CD) at t0+1 and (0x301,AB) at t0+2; done at t0+3; RAM[0x302] unchanged.
- Load and save together, then wrap:
  - load=save=1 -> only reads occur, mem_wr never 1.
  - Address 0x1FFFF, length 2 -> second byte accessed at mem_a=0.
- Reset mid-operation: rst=0 during a 4-byte save after byte 1 -> mem_wr=0 and done=0 immediately; after release, IDLE and no further writes.
- With MEMCTRL_IO_WAIT_EN: save of 1 byte to 0x30000 with io_buffer_full=1 for 3 cycles -> write occurs once after release, done at t0+5.
